// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: register-file geometry and architectural register indices.
package rv32i_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
  localparam reg_addr_t REG_SP   = reg_addr_t'(2);

endpackage

// File: rtl/regfile_if.sv
// Register-file access bundle: two combinational read ports and one clocked write port.
interface regfile_if #(
  parameter int WIDTH = 32
);
  import rv32i_pkg::*;

  logic             we3;
  reg_addr_t        a1;
  reg_addr_t        a2;
  reg_addr_t        a3;
  logic [WIDTH-1:0] wd3;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  // The datapath drives addresses and write data; the register file returns read data.
  modport master (output we3, a1, a2, a3, wd3, input  rd1, rd2);
  modport slave  (input  we3, a1, a2, a3, wd3, output rd1, rd2);

endinterface

// File: rtl/flopenr.sv
// Resettable enabled flop with a per-instance reset value; one instance holds one register.
module flopenr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile.sv
// RV32I integer register file: x0 hard-wired to zero, x1..x31 in flops, x2 resets to SP_INIT.
module regfile
  import rv32i_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter logic [31:0] SP_INIT = 32'h0000_0000,
  parameter bit          BYPASS  = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  rf
);

  localparam logic [WIDTH-1:0] SP_RESET = WIDTH'(SP_INIT);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             fwd_ok;
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;

  assign regs[0] = '0;

  // NOTE: every architectural register is its own resettable flop, so the whole array
  // clears asynchronously; this is why it is not written as an inferred memory.
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
    localparam logic [WIDTH-1:0] RV = (reg_addr_t'(i) == REG_SP) ? SP_RESET : '0;

    flopenr #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RV)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .en    (rf.we3 && (rf.a3 == reg_addr_t'(i))),
      .d     (rf.wd3),
      .q     (regs[i])
    );
  end

  // Forwarding only applies to writes that will actually land in the array.
  assign fwd_ok = BYPASS && rf.we3 && (rf.a3 != REG_ZERO);

  // NOTE: defaults first, then overrides, so no path leaves the outputs unassigned (no latch).
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (rf.a1 != REG_ZERO) rd1_c = regs[rf.a1];
    if (rf.a2 != REG_ZERO) rd2_c = regs[rf.a2];
    if (fwd_ok && (rf.a1 == rf.a3)) rd1_c = rf.wd3;
    if (fwd_ok && (rf.a2 == rf.a3)) rd2_c = rf.wd3;
  end

  assign rf.rd1 = rd1_c;
  assign rf.rd2 = rd2_c;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: one non-bypassing and one bypassing instance fed identical stimulus.
module tb_regfile;
  import rv32i_pkg::*;

  localparam logic [31:0] SP = 32'h0001_0000;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  regfile_if #(.WIDTH(32)) bus0 ();
  regfile_if #(.WIDTH(32)) bus1 ();

  assign bus1.we3 = bus0.we3;
  assign bus1.a1  = bus0.a1;
  assign bus1.a2  = bus0.a2;
  assign bus1.a3  = bus0.a3;
  assign bus1.wd3 = bus0.wd3;

  regfile #(.WIDTH(32), .SP_INIT(SP), .BYPASS(1'b0)) dut0 (.clk(clk), .reset(reset), .rf(bus0));
  regfile #(.WIDTH(32), .SP_INIT(SP), .BYPASS(1'b1)) dut1 (.clk(clk), .reset(reset), .rf(bus1));

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] model [32];
  vec_t        vecs  [12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = SP;
  endtask

  task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    bus0.we3 = we;
    bus0.a3  = a3;
    bus0.wd3 = wd;
    bus0.a1  = a1;
    bus0.a2  = a2;
  endtask

  // Read every register on both ports of both instances, against the bench model.
  task automatic sweep(input string nm);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      check({nm, "_d0_rd1"}, bus0.rd1, model[i]);
      check({nm, "_d0_rd2"}, bus0.rd2, model[31 - i]);
      check({nm, "_d1_rd1"}, bus1.rd1, model[i]);
      check({nm, "_d1_rd2"}, bus1.rd2, model[31 - i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5, 5'd2,  32'hDEAD_BEEF, SP};
    vecs[1]  = '{1'b1, 5'd31, 32'h0000_007F, 5'd5, 5'd31, 32'hDEAD_BEEF, 32'h0000_007F};
    vecs[2]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0, 5'd5,  32'h0,         32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd0, 32'h0000_007F, 32'h0};
    vecs[4]  = '{1'b1, 5'd9,  32'h0000_0099, 5'd9, 5'd3,  32'h0000_0099, 32'h0};
    vecs[5]  = '{1'b0, 5'd9,  32'hAAAA_AAAA, 5'd9, 5'd9,  32'h0000_0099, 32'h0000_0099};
    vecs[6]  = '{1'b0, 5'd9,  32'hAAAA_AAAA, 5'd9, 5'd9,  32'h0000_0099, 32'h0000_0099};
    vecs[7]  = '{1'b0, 5'd9,  32'hAAAA_AAAA, 5'd9, 5'd9,  32'h0000_0099, 32'h0000_0099};
    vecs[8]  = '{1'b1, 5'd9,  32'h0000_0011, 5'd9, 5'd5,  32'h0000_0011, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 5'd9,  32'h0000_0022, 5'd9, 5'd31, 32'h0000_0022, 32'h0000_007F};
    vecs[10] = '{1'b1, 5'd2,  32'hCAFE_0000, 5'd2, 5'd1,  32'hCAFE_0000, 32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         5'd1, 5'd2,  32'h0,         32'hCAFE_0000};

    // Reset held across edges with a write presented: the write must be lost.
    reset = 1'b1;
    drive(1'b1, 5'd5, 32'h5555_5555, 5'd5, 5'd2);
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_write_lost_d0", bus0.rd1, 32'h0);
    check("rst_sp_d0",         bus0.rd2, SP);
    sweep("rst");

    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    for (int v = 0; v < 12; v++) begin
      @(negedge clk);
      drive(vecs[v].we, vecs[v].a3, vecs[v].wd, vecs[v].a1, vecs[v].a2);
      @(posedge clk); #1;
      check($sformatf("vec%0d_d0_rd1", v), bus0.rd1, vecs[v].e1);
      check($sformatf("vec%0d_d0_rd2", v), bus0.rd2, vecs[v].e2);
      check($sformatf("vec%0d_d1_rd1", v), bus1.rd1, vecs[v].e1);
      check($sformatf("vec%0d_d1_rd2", v), bus1.rd2, vecs[v].e2);
      if (vecs[v].we && vecs[v].a3 != 5'd0) model[vecs[v].a3] = vecs[v].wd;
    end
    sweep("after_vecs");

    // Same-cycle read/write of x7: old value without bypass, new value with it.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd5);
    #1;
    check("rw7_pre_d0",     bus0.rd1, 32'h0);
    check("rw7_pre_d1",     bus1.rd1, 32'h1234_5678);
    check("rw7_pre_d1_rd2", bus1.rd2, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("rw7_post_d0", bus0.rd1, 32'h1234_5678);
    check("rw7_post_d1", bus1.rd1, 32'h1234_5678);
    model[7] = 32'h1234_5678;

    // A write aimed at x0 is never forwarded.
    @(negedge clk);
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    #1;
    check("x0_nofwd_d1_rd1", bus1.rd1, 32'h0);
    check("x0_nofwd_d1_rd2", bus1.rd2, 32'h0);
    @(posedge clk); #1;
    check("x0_post_d0", bus0.rd1, 32'h0);

    // Fill x1..x31 with their index.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0);
      model[i] = 32'(i);
    end
    sweep("fill");

    // Asynchronous reset between edges with a write pending.
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h0000_EEEE, 5'd4, 5'd2);
    #1;
    check("pre_rst_x4_d0", bus0.rd1, 32'h4);
    check("pre_rst_x2_d0", bus0.rd2, 32'h2);
    #1 reset = 1'b1;
    #1;
    check("async_rst_x4_d0", bus0.rd1, 32'h0);
    check("async_rst_x2_d0", bus0.rd2, SP);
    check("async_rst_x2_d1", bus1.rd2, SP);
    bus0.a1 = 5'd31;
    #1;
    check("async_rst_x31_d0", bus0.rd1, 32'h0);
    check("async_rst_x31_d1", bus1.rd1, 32'h0);
    bus0.a1 = 5'd4;
    @(posedge clk); #1;
    check("rst_edge_write_lost_d0", bus0.rd1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    model_reset();
    sweep("post_rst");

    // Reset values persist across idle edges until rewritten.
    @(negedge clk);
    drive(1'b0, 5'd4, 32'h0000_0044, 5'd4, 5'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_x4_d0", bus0.rd1, 32'h0);
    check("idle_x2_d0", bus0.rd2, SP);
    @(negedge clk);
    bus0.we3 = 1'b1;
    @(posedge clk); #1;
    check("rewrite_x4_d0", bus0.rd1, 32'h0000_0044);
    check("rewrite_x4_d1", bus1.rd1, 32'h0000_0044);
    check("rewrite_x2_d0", bus0.rd2, SP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
